gpio_pad_ctrl: RTL and testbench



---
 rtl/gpio_pkg.sv | 26 ++
 rtl/gpio_pin_filter.sv | 55 +++++
 rtl/gpio_pad_ctrl.sv | 84 ++++++++
 tb/tb_gpio_pad_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants and pad-mode decode for the GPIO pad controller and its benches.
package gpio_pkg;

  localparam int GPIO_WIDTH       = 8;
  localparam int GPIO_SYNC_STAGES = 2;
  localparam int GPIO_DB_W        = 4;

  typedef enum logic [1:0] {
    PAD_IN,
    PAD_PUSHPULL,
    PAD_OPENDRAIN
  } pad_mode_e;

  // Per-pin result of the input filter.
  typedef struct packed {
    logic data;
    logic rise;
    logic fall;
  } pin_evt_t;

  function automatic pad_mode_e pad_mode(input logic oe, input logic od);
    if (!oe) return PAD_IN;
    return od ? PAD_OPENDRAIN : PAD_PUSHPULL;
  endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// One pin: input synchroniser, debounce counter and filtered edge detect.
module gpio_pin_filter
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DB_W        = GPIO_DB_W
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            pad,
  input  logic [DB_W-1:0] db_limit,
  output pin_evt_t        evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   filt;
  logic [DB_W-1:0]        cnt;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // >= rather than == so a limit lowered mid-count fires on the next edge
  // instead of letting cnt run past the limit and wrap.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      filt <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == filt) begin
        cnt <= '0;
      end else if (cnt >= db_limit) begin
        filt <= sync;
        cnt  <= '0;
        rise <= sync;
        fall <= ~sync;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

  assign evt = '{data: filt, rise: rise, fall: fall};

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: push-pull/open-drain pad drive, filtered inputs with
// edge pulses, and sticky maskable edge interrupts.
module gpio_pad_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DB_W        = GPIO_DB_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] gpio_data_out,
  input  logic [WIDTH-1:0] gpio_oe,
  input  logic [WIDTH-1:0] gpio_od,
  input  logic [DB_W-1:0]  db_limit,
  input  logic [WIDTH-1:0] irq_rise_en,
  input  logic [WIDTH-1:0] irq_fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] gpio_data_in,
  output logic [WIDTH-1:0] gpio_rise,
  output logic [WIDTH-1:0] gpio_fall,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq,
  inout  wire  [WIDTH-1:0] pad_io
);

  logic [WIDTH-1:0] pad_en;
  logic [WIDTH-1:0] pad_val;
  logic [WIDTH-1:0] irq_set;
  pin_evt_t [WIDTH-1:0] pin_evt;

  // Open-drain only ever pulls low; a high data bit releases the pad.
  always_comb begin
    pad_en  = '0;
    pad_val = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (pad_mode(gpio_oe[i], gpio_od[i]))
        PAD_PUSHPULL: begin
          pad_en[i]  = 1'b1;
          pad_val[i] = gpio_data_out[i];
        end
        PAD_OPENDRAIN: begin
          pad_en[i]  = ~gpio_data_out[i];
          pad_val[i] = 1'b0;
        end
        default: begin
          pad_en[i]  = 1'b0;
          pad_val[i] = 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign pad_io[i] = pad_en[i] ? pad_val[i] : 1'bz;

    // Pad is sampled even while driven so loopback reaches gpio_data_in.
    gpio_pin_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_W        (DB_W)
    ) u_filt (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .pad      (pad_io[i]),
      .db_limit (db_limit),
      .evt      (pin_evt[i])
    );

    assign gpio_data_in[i] = pin_evt[i].data;
    assign gpio_rise[i]    = pin_evt[i].rise;
    assign gpio_fall[i]    = pin_evt[i].fall;
  end

  assign irq_set = (gpio_rise & irq_rise_en) | (gpio_fall & irq_fall_en);

  // A new event outranks a clear landing on the same edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) irq_status <= '0;
    else         irq_status <= irq_set | (irq_status & ~irq_clr);
  end

  assign irq = |irq_status;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench: directed 8-pin vectors plus a 32-pin, 3-stage build under random pad activity.
module tb_gpio_pad_ctrl;
  import gpio_pkg::*;

  localparam int W   = 8;
  localparam int DBW = 4;
  localparam int W2  = 32;
  localparam int S2  = 3;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  logic [W-1:0]   data_out, oe, od, ren, fen, clr;
  logic [W-1:0]   din, rise, fall, stat;
  logic           irq;
  logic [DBW-1:0] db;
  logic [W-1:0]   ext_en, ext_val;
  wire  [W-1:0]   pad;

  for (genvar g = 0; g < W; g++) begin : g_ext
    assign pad[g] = ext_en[g] ? ext_val[g] : 1'bz;
  end

  gpio_pad_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .DB_W(DBW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .gpio_data_out(data_out), .gpio_oe(oe), .gpio_od(od), .db_limit(db),
    .irq_rise_en(ren), .irq_fall_en(fen), .irq_clr(clr),
    .gpio_data_in(din), .gpio_rise(rise), .gpio_fall(fall),
    .irq_status(stat), .irq(irq), .pad_io(pad)
  );

  logic            rst32;
  logic [W2-1:0]   p32, ren32, fen32, clr32, din32, rise32, fall32, stat32;
  logic            irq32;
  logic [DBW-1:0]  db32;
  wire  [W2-1:0]   pad32;
  assign pad32 = p32;

  gpio_pad_ctrl #(.WIDTH(W2), .SYNC_STAGES(S2), .DB_W(DBW)) dut32 (
    .sys_clk(sys_clk), .sys_rst(rst32),
    .gpio_data_out('0), .gpio_oe('0), .gpio_od('0), .db_limit(db32),
    .irq_rise_en(ren32), .irq_fall_en(fen32), .irq_clr(clr32),
    .gpio_data_in(din32), .gpio_rise(rise32), .gpio_fall(fall32),
    .irq_status(stat32), .irq(irq32), .pad_io(pad32)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef enum {K_DIN, K_PAD, K_STAT, K_IRQ} kind_e;
  typedef struct { int at; kind_e k; logic [W-1:0] val; string name; } chk_t;
  typedef struct { int at; logic [W-1:0] r; logic [W-1:0] f; } evt_t;
  chk_t chkq[$];
  evt_t evq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rand_done = 0;

  task automatic chk(input int dly, input kind_e k, input logic [W-1:0] v, input string nm);
    chk_t c;
    c.at = cyc + dly; c.k = k; c.val = v; c.name = nm;
    chkq.push_back(c);
  endtask

  task automatic evt(input int dly, input logic [W-1:0] r, input logic [W-1:0] f);
    evt_t e;
    e.at = cyc + dly; e.r = r; e.f = f;
    evq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Level checks fire on their scheduled cycle; edge records are popped whenever the DUT pulses.
  logic [W-1:0] act;
  evt_t         ev;
  always @(negedge sys_clk) begin
    for (int i = chkq.size() - 1; i >= 0; i--) begin
      if (chkq[i].at == cyc) begin
        case (chkq[i].k)
          K_DIN:   act = din;
          K_PAD:   act = pad;
          K_STAT:  act = stat;
          default: act = {{(W-1){1'b0}}, irq};
        endcase
        n_cmp++;
        if (act !== chkq[i].val) begin
          n_bad++;
          $display("FAIL %s: got %h want %h (cyc %0d)", chkq[i].name, act, chkq[i].val, cyc);
        end
        chkq.delete(i);
      end
    end
    if ((rise | fall) != '0) begin
      n_cmp++;
      if (evq.size() == 0) begin
        n_bad++;
        $display("FAIL edge_unexpected: got rise %h fall %h want none (cyc %0d)", rise, fall, cyc);
      end else begin
        ev = evq.pop_front();
        if (ev.at != cyc || ev.r !== rise || ev.f !== fall) begin
          n_bad++;
          $display("FAIL edge: got cyc %0d rise %h fall %h want cyc %0d rise %h fall %h",
                   cyc, rise, fall, ev.at, ev.r, ev.f);
        end
      end
    end
  end

  // 32-pin build against a run-length reference of the filter.
  initial begin : rand_blk
    logic [W2-1:0] chain [S2];
    logic [W2-1:0] mf, mr, mfl, ms, ms_n, nr, nf, pv, cv;
    logic [DBW-1:0] dv;
    logic rv, s;
    int run [W2];
    rst32 = 1'b1; p32 = '0; db32 = 4'd2; clr32 = '0;
    ren32 = $urandom; fen32 = $urandom;
    pv = '0; dv = 4'd2; cv = '0; rv = 1'b1;
    mf = '0; mr = '0; mfl = '0; ms = '0;
    for (int k = 0; k < S2; k++) chain[k] = '0;
    for (int i = 0; i < W2; i++) run[i] = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge sys_clk);
      if (rv) begin
        mf = '0; mr = '0; mfl = '0; ms = '0;
        for (int k = 0; k < S2; k++) chain[k] = '0;
        for (int i = 0; i < W2; i++) run[i] = 0;
      end else begin
        ms_n = (mr & ren32) | (mfl & fen32) | (ms & ~cv);
        nr = '0; nf = '0;
        for (int i = 0; i < W2; i++) begin
          s = chain[S2-1][i];
          if (s != mf[i]) begin
            run[i]++;
            if (run[i] > int'(dv)) begin
              mf[i] = s; run[i] = 0; nr[i] = s; nf[i] = ~s;
            end
          end else run[i] = 0;
        end
        for (int k = S2 - 1; k > 0; k--) chain[k] = chain[k-1];
        chain[0] = pv;
        mr = nr; mfl = nf; ms = ms_n;
      end
      n_cmp++;
      if ({din32, rise32, fall32, stat32, irq32} !== {mf, mr, mfl, ms, |ms}) begin
        n_bad++;
        $display("FAIL rand32: got din %h r %h f %h st %h irq %b want din %h r %h f %h st %h irq %b (n %0d)",
                 din32, rise32, fall32, stat32, irq32, mf, mr, mfl, ms, |ms, n);
      end
      rst32 = (n < 4) || (n >= 300 && n < 303);
      p32   = p32 ^ ($urandom & $urandom & $urandom);
      if (n % 64 == 0) begin
        case ((n / 64) % 5)
          0: db32 = 4'd2;
          1: db32 = 4'd0;
          2: db32 = 4'd5;
          3: db32 = 4'd1;
          default: db32 = 4'd3;
        endcase
      end
      clr32 = ($urandom_range(0, 7) == 0) ? $urandom : '0;
      pv = p32; dv = db32; cv = clr32; rv = rst32;
    end
    rand_done = 1;
  end

  initial begin
    sys_rst = 1'b1; ext_en = '1; ext_val = '0; oe = '0; od = '0; data_out = '0;
    db = 4'd3; ren = '0; fen = '0; clr = '0;
    step(3);
    chk(0, K_DIN, 8'h00, "rst_din"); chk(0, K_STAT, 8'h00, "rst_stat"); chk(0, K_IRQ, 8'h00, "rst_irq");
    step(1); sys_rst = 1'b0;
    step(2);

    // pad drive and loopback
    ext_en = '0; oe = '1; data_out = 8'hA5;
    chk(0, K_PAD, 8'hA5, "pp_pad"); chk(5, K_DIN, 8'h00, "pp_din_early"); chk(6, K_DIN, 8'hA5, "pp_din");
    evt(6, 8'hA5, 8'h00);
    step(10);
    od = '1; ext_en = 8'hA5; ext_val = 8'hFF;
    chk(0, K_PAD, 8'hA5, "od_pullup");
    step(10);
    ext_val = 8'h00;
    chk(0, K_PAD, 8'h00, "od_low"); evt(6, 8'h00, 8'hA5);
    step(10);
    oe = '0; od = '0; ext_en = '1; ext_val = 8'h3C;
    chk(0, K_PAD, 8'h3C, "oe_off_pad"); evt(6, 8'h3C, 8'h00);
    step(10);
    ext_val = 8'h00; evt(6, 8'h00, 8'h3C);
    step(10);

    // debounce, db_limit=3
    ext_val = 8'h01;
    chk(5, K_DIN, 8'h00, "db_early"); chk(6, K_DIN, 8'h01, "db_din"); evt(6, 8'h01, 8'h00);
    step(10);
    ext_val = 8'h00; step(3); ext_val = 8'h01;
    step(10);
    chk(0, K_DIN, 8'h01, "glitch_reject");
    ext_val = 8'h00; evt(6, 8'h00, 8'h01);
    step(10);

    // bypass
    db = 4'd0; ext_val = 8'h02;
    chk(2, K_DIN, 8'h00, "byp_early"); chk(3, K_DIN, 8'h02, "byp_din"); evt(3, 8'h02, 8'h00);
    step(6);
    ext_val = 8'h00; evt(3, 8'h00, 8'h02);
    step(6);

    // lower the limit while cnt=5
    db = 4'd7; ext_val = 8'h04;
    chk(7, K_DIN, 8'h00, "lim_hold"); chk(8, K_DIN, 8'h04, "lim_din"); evt(8, 8'h04, 8'h00);
    step(7); db = 4'd2;
    step(5); db = 4'd3; ext_val = 8'h00; evt(6, 8'h00, 8'h04);
    step(10);

    // interrupts
    ren = 8'h01; fen = 8'h02; ext_val = 8'h03;
    evt(6, 8'h03, 8'h00); chk(6, K_STAT, 8'h00, "irq_pre"); chk(7, K_STAT, 8'h01, "irq_rise_set");
    step(10);
    ext_val = 8'h01;
    evt(6, 8'h00, 8'h02); chk(7, K_STAT, 8'h03, "irq_fall_set"); chk(7, K_IRQ, 8'h01, "irq_on");
    step(10);
    ext_val = 8'h00; evt(6, 8'h00, 8'h01); chk(7, K_STAT, 8'h03, "fall_masked");
    step(10);
    ext_val = 8'h01; evt(6, 8'h01, 8'h00);
    step(6); clr = 8'h01; chk(1, K_STAT, 8'h03, "set_wins");
    step(1); clr = 8'h00;
    step(1); ren = '0; fen = '0; chk(1, K_STAT, 8'h03, "en_no_clear");
    step(1); clr = 8'h02; chk(1, K_STAT, 8'h01, "clr_bit1"); chk(1, K_IRQ, 8'h01, "irq_still");
    step(1); clr = 8'h01; chk(1, K_STAT, 8'h00, "clr_bit0"); chk(1, K_IRQ, 8'h00, "irq_off");
    step(1); clr = 8'h00;
    step(5);

    // async reset mid-debounce
    ren = 8'hFF; ext_val = 8'h81;
    step(4); sys_rst = 1'b1;
    chk(0, K_DIN, 8'h00, "arst_din");
    step(3); sys_rst = 1'b0;
    chk(5, K_DIN, 8'h00, "rel_early"); chk(6, K_DIN, 8'h81, "rel_din"); evt(6, 8'h81, 8'h00);
    chk(7, K_STAT, 8'h81, "rel_stat");
    step(12);

    for (int g = 0; g < 2000 && !rand_done; g++) step(1);
    n_cmp++;
    if (!rand_done) begin
      n_bad++;
      $display("FAIL rand_timeout: got running want done");
    end
    n_cmp++;
    if (chkq.size() != 0 || evq.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d checks %0d edges pending want 0 0", chkq.size(), evq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
